// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_DONE
  } sched_state_t;

  // Serial bits per frame: start, 8 data, stop.
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr wins.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);

  localparam int IW = $clog2(N);
  localparam int SW = IW + 1;

  logic [SW-1:0] sum;
  logic [IW-1:0] pos;

  // Walk offsets from farthest to nearest so the nearest set request is the last write.
  always_comb begin
    gnt = '0;
    idx = '0;
    sum = '0;
    pos = '0;
    any = |req;
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + SW'(k);
      if (sum >= SW'(N)) sum = sum - SW'(N);
      pos = sum[IW-1:0];
      if (req[pos]) begin
        gnt      = '0;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among NUM_REQ byte sources.
// Optional burst regrant is enabled by defining UART_TX_SCHED_BURST_EN.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int TIMEOUT   = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                       bclk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*8-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 thr,
  output logic                       tx_en,
  input  logic                       tx_status,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       err_timeout,
  input  logic                       err_clr,
  output sched_state_t               dbg_state
);

  localparam int IW   = $clog2(NUM_REQ);
  localparam int WD_W = ($clog2(TIMEOUT) > 0) ? $clog2(TIMEOUT) : 1;

  sched_state_t  state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] arb_ptr;
  logic [WD_W-1:0] wd_cnt;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IW-1:0]      arb_idx;
  logic               arb_any;
  logic               accept_idle;
  logic               regrant;
  logic [IW-1:0]      sel_idx;
  logic [7:0]         sel_byte;

  assign dbg_state = state;

  // Scan begins one past the last winner so every source gets a turn.
  assign arb_ptr = (rr_ptr == IW'(NUM_REQ - 1)) ? '0 : rr_ptr + 1'b1;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req (req_valid),
    .ptr (arb_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign accept_idle = (state == S_IDLE) && arb_any;

`ifdef UART_TX_SCHED_BURST_EN
  localparam int BW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  logic [BW-1:0] burst_cnt;

  assign regrant = (state == S_DONE) && req_valid[grant_id] &&
                   (burst_cnt < BW'(MAX_BURST - 1));

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      burst_cnt <= '0;
    end else if (regrant) begin
      burst_cnt <= burst_cnt + 1'b1;
    end else if (state == S_DONE || state == S_IDLE) begin
      burst_cnt <= '0;
    end
  end
`else
  logic [31:0] unused_max_burst;
  assign unused_max_burst = 32'(MAX_BURST);
  assign regrant          = 1'b0;
`endif

  assign sel_idx  = regrant ? grant_id : arb_idx;
  assign sel_byte = req_data[{sel_idx, 3'b000} +: 8];

  // Handshake: req_valid[i] offers req_data[i]; a req_ready[i] pulse means the byte
  // is taken at this rising edge. Only one ready fires per cycle, never outside IDLE
  // (or DONE on a burst regrant), and never while rst is high.
  always_comb begin
    req_ready = '0;
    if (!rst) begin
      if (accept_idle) req_ready = arb_gnt;
      else if (regrant) req_ready[grant_id] = 1'b1;
    end
  end

  always_ff @(posedge bclk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      thr         <= 8'h00;
      tx_en       <= 1'b0;
      grant_id    <= '0;
      rr_ptr      <= '0;
      err_timeout <= 1'b0;
      wd_cnt      <= '0;
      busy        <= 1'b0;
    end else begin
      // A timeout below overrides this clear in the same cycle.
      if (err_clr) err_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            thr      <= sel_byte;
            grant_id <= arb_idx;
            rr_ptr   <= arb_idx;
            tx_en    <= 1'b1;
            wd_cnt   <= '0;
            busy     <= 1'b1;
            state    <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (tx_status) begin
            tx_en  <= 1'b0;
            wd_cnt <= '0;
            state  <= S_BUSY;
          end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            tx_en       <= 1'b0;
            wd_cnt      <= '0;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        S_BUSY: begin
          if (!tx_status) state <= S_DONE;
        end
        S_DONE: begin
          // One settling cycle lets the transmitter finish STOP before the next start.
          if (regrant) begin
            thr    <= sel_byte;
            tx_en  <= 1'b1;
            wd_cnt <= '0;
            state  <= S_LAUNCH;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          tx_en <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: timestamp-based model, transmitter emulation, byte scoreboard.
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int N     = 4;
  localparam int TO    = 8;
  localparam int MB    = 4;
  localparam int FB    = FRAME_BITS;
  localparam int NEVER = 1 << 30;

  logic               bclk;
  logic               rst;
  logic [N-1:0]       req_valid;
  logic [N*8-1:0]     req_data;
  logic [N-1:0]       req_ready;
  logic [7:0]         thr;
  logic               tx_en;
  logic               tx_status;
  logic [1:0]         grant_id;
  logic               busy;
  logic               err_timeout;
  logic               err_clr;
  sched_state_t       dbg_state;

  uart_tx_scheduler #(.NUM_REQ(N), .TIMEOUT(TO), .MAX_BURST(MB)) dut (
    .bclk(bclk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .thr(thr), .tx_en(tx_en), .tx_status(tx_status),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout),
    .err_clr(err_clr), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  int cyc = 0;
  always @(posedge bclk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- transmitter emulation ----------------
  int          tx_cnt;
  logic [9:0]  tx_sh;
  bit          tx_dead = 0;
  logic        bit_q[$];
  logic [7:0]  exp_q[$];

  assign tx_status = (tx_cnt >= 1) && (tx_cnt <= FB);

  always @(posedge bclk or posedge rst) begin
    if (rst) begin
      tx_cnt <= 0;
    end else if (tx_cnt == 0) begin
      if (tx_en && !tx_dead) begin
        tx_cnt <= 1;
        tx_sh  <= {1'b1, thr, 1'b0};
      end
    end else if (tx_cnt <= FB) begin
      bit_q.push_back(tx_sh[tx_cnt-1]);
      if (tx_cnt == FB) begin
        if (exp_q.size() == 0) check("sb_orphan_frame", 1, 0);
        else check("sb_frame_byte", tx_sh[8:1], exp_q.pop_front());
      end
      tx_cnt <= tx_cnt + 1;
    end else begin
      tx_cnt <= 0;
    end
  end

  // ---------------- behavioural model + compare ----------------
  int free_at, launch_from, seen_at, done_at;
  int m_ptr, m_grant, m_burst;
  logic [7:0] m_thr;
  logic       m_err;
  int acc_cyc[$];
  int acc_idx[$];
  int en_cnt;

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 1; k <= N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  always @(negedge bclk) begin
    logic [N-1:0] exp_rdy;
    bit idle, in_launch, regrant, set_err;
    int w;
    if (rst) begin
      free_at = 0; launch_from = NEVER; seen_at = -1; done_at = -1;
      m_ptr = 0; m_grant = 0; m_burst = 0; m_thr = 8'h00; m_err = 1'b0;
      exp_q.delete();
      check("rst_req_ready", req_ready, 0);
      check("rst_tx_en", tx_en, 0);
      check("rst_busy", busy, 0);
      check("rst_thr", thr, 0);
      check("rst_grant", grant_id, 0);
      check("rst_err", err_timeout, 0);
      check("rst_state", dbg_state, S_IDLE);
    end else begin
      idle      = (cyc >= free_at);
      in_launch = (cyc >= launch_from) && (cyc < launch_from + TO);
      regrant   = 0;
`ifdef UART_TX_SCHED_BURST_EN
      regrant = (cyc == done_at) && req_valid[m_grant] && (m_burst < MB - 1);
`endif
      exp_rdy = '0;
      w = 0;
      if (idle && |req_valid) begin
        w = pick(req_valid, m_ptr);
        exp_rdy[w] = 1'b1;
      end else if (regrant) begin
        exp_rdy[m_grant] = 1'b1;
      end

      check("req_ready", req_ready, exp_rdy);
      check("tx_en", tx_en, in_launch);
      check("busy", busy, !idle);
      check("thr", thr, m_thr);
      check("grant_id", grant_id, m_grant);
      check("err_timeout", err_timeout, m_err);

      if (tx_en) en_cnt++;
      if (req_ready != 0) begin
        acc_cyc.push_back(cyc);
        for (int i = 0; i < N; i++) if (req_ready[i]) acc_idx.push_back(i);
      end

      set_err = 0;
      if (in_launch && tx_status) begin
        seen_at = cyc;
        launch_from = NEVER;
        exp_q.push_back(m_thr);
      end else if (in_launch && cyc == launch_from + TO - 1) begin
        set_err = 1;
        free_at = cyc + 1;
        launch_from = NEVER;
      end else if (seen_at >= 0 && cyc > seen_at && !tx_status) begin
        done_at = cyc + 1;
        free_at = cyc + 2;
        seen_at = -1;
      end
      if (cyc == done_at && !regrant) m_burst = 0;
      if (exp_rdy != 0) begin
        if (regrant) m_burst++;
        else begin
          m_burst = 0;
          m_grant = w;
          m_ptr   = w;
        end
        m_thr = req_data[m_grant*8 +: 8];
        launch_from = cyc + 1;
        free_at = NEVER;
      end
      if (set_err) m_err = 1'b1;
      else if (err_clr) m_err = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge bclk);
    #1;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) tick(1);
    check("wait_idle_bound", busy, 0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    logic [9:0] got;
    int exp_ord[5];
    int exp_gap[4];
    rst = 1'b1; req_valid = '0; req_data = '0; err_clr = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Test 1: single byte from source 0, bit-level frame check.
    bit_q.delete();
    req_data = {8'h44, 8'h33, 8'h22, 8'hA5};
    req_valid = 4'b0001;
    #1;
    check("t1_ready_c0", req_ready, 4'b0001);
    tick(1);
    check("t1_tx_en_c1", tx_en, 1);
    check("t1_ready_c1", req_ready, 0);
    req_valid = '0;
    wait_idle();
    check("t1_thr_held", thr, 8'hA5);
    check("t1_bit_count", bit_q.size(), 10);
    got = '0;
    for (int i = 0; i < 10 && i < bit_q.size(); i++) got[9-i] = bit_q[i];
    check("t1_bits", got, 10'b0101001011);

    // Test 2: all sources valid, round-robin from ptr 0.
    acc_cyc.delete(); acc_idx.delete();
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    req_valid = 4'b1111;
    for (int i = 0; i < 200 && acc_idx.size() < 5; i++) tick(1);
    req_valid = '0;
    check("t2_accepts", acc_idx.size(), 5);
`ifdef UART_TX_SCHED_BURST_EN
    exp_ord = '{1, 1, 1, 1, 2};
    exp_gap = '{13, 13, 13, 14};
`else
    exp_ord = '{1, 2, 3, 0, 1};
    exp_gap = '{14, 14, 14, 14};
`endif
    if (acc_idx.size() >= 5) begin
      for (int k = 0; k < 5; k++) check("t2_order", acc_idx[k], exp_ord[k]);
      for (int k = 0; k < 4; k++) check("t2_spacing", acc_cyc[k+1] - acc_cyc[k], exp_gap[k]);
    end
    wait_idle();

    // Test 6: a one-cycle request while BUSY is ignored.
    acc_idx.delete(); acc_cyc.delete();
    req_data = {8'hEE, 8'h5C, 8'h00, 8'h00};
    req_valid = 4'b0100;
    tick(1);
    req_valid = '0;
    tick(3);
    req_valid = 4'b1000;
    tick(1);
    req_valid = '0;
    wait_idle();
    tick(3);
    check("t6_accepts", acc_idx.size(), 1);
    if (acc_idx.size() >= 1) check("t6_src", acc_idx[0], 2);

    // Test 3: transmitter never responds -> watchdog, then clear, then set-wins.
    tx_dead = 1;
    en_cnt = 0;
    req_data = {8'h00, 8'h00, 8'h00, 8'h77};
    req_valid = 4'b0001;
    tick(1);
    req_valid = '0;
    wait_idle();
    check("t3_tx_en_cycles", en_cnt, 8);
    check("t3_err_set", err_timeout, 1);
    err_clr = 1'b1;
    tick(1);
    err_clr = 1'b0;
    check("t3_err_cleared", err_timeout, 0);
    err_clr = 1'b1;
    req_valid = 4'b0001;
    tick(1);
    req_valid = '0;
    wait_idle();
    check("t3_set_wins", err_timeout, 1);
    err_clr = 1'b0;
    tick(1);
    tx_dead = 0;

    // Test 4: asynchronous reset in BUSY.
    req_data = {8'h91, 8'h82, 8'h73, 8'h64};
    req_valid = 4'b0010;
    tick(1);
    req_valid = '0;
    tick(4);
    check("t4_pre_busy", dbg_state, S_BUSY);
    req_valid = 4'b1111;
    #2;
    rst = 1'b1;
    #1;
    check("t4_busy", busy, 0);
    check("t4_tx_en", tx_en, 0);
    check("t4_thr", thr, 0);
    check("t4_ready", req_ready, 0);
    check("t4_grant", grant_id, 0);
    check("t4_err", err_timeout, 0);
    tick(3);
    acc_idx.delete(); acc_cyc.delete();
    rst = 1'b0;
    tick(1);
    req_valid = '0;
    wait_idle();
    check("t4_post_accepts", acc_idx.size(), 1);
    if (acc_idx.size() >= 1) check("t4_post_src", acc_idx[0], 1);

`ifdef UART_TX_SCHED_BURST_EN
    // Test 5: bursts of MAX_BURST from sources 2 and 0 (ptr is 1 here).
    acc_idx.delete(); acc_cyc.delete();
    req_data = {8'h00, 8'h2B, 8'h00, 8'h0A};
    req_valid = 4'b0101;
    for (int i = 0; i < 300 && acc_idx.size() < 8; i++) tick(1);
    req_valid = '0;
    check("t5_accepts", acc_idx.size(), 8);
    if (acc_idx.size() >= 8) begin
      for (int k = 0; k < 8; k++) check("t5_order", acc_idx[k], (k < 4) ? 2 : 0);
      for (int k = 0; k < 7; k++) check("t5_spacing", acc_cyc[k+1] - acc_cyc[k], (k == 3) ? 14 : 13);
    end
    wait_idle();
`endif

    tick(5);
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d actual=running required=finished", cyc);
    $fatal(1);
  end

endmodule
